tcp_rx_scheduler: RTL and testbench

- Shares the single TCP segment decoder between two ingress segment queues (IP receive paths 0 and 1).
- Arbitrates round-robin between queued segments and clears the decoder between segments.
- Streams each segment into the decoder at one word per cycle, with no gaps.
- Waits for the decoder's completion flag and reports a per-segment status, with a watchdog against decoder hangs.

---
 rtl/tcp_rx_scheduler_if.sv | 48 ++++
 rtl/tcp_rx_scheduler.sv | 152 +++++++++++++++
 tb/tb_tcp_rx_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_rx_scheduler_if.sv
// rtl/tcp_rx_scheduler_if.sv - ingress queue, decoder and status signals of the TCP RX scheduler
interface tcp_rx_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             req_0;
  logic             req_1;
  logic [15:0]      len_0;
  logic [15:0]      len_1;
  logic [31:0]      src_ip_0;
  logic [31:0]      src_ip_1;
  logic [31:0]      dst_ip_0;
  logic [31:0]      dst_ip_1;
  logic [31:0]      rd_data_0;
  logic [31:0]      rd_data_1;
  logic             rd_en_0;
  logic             rd_en_1;
  logic             dec_reset;
  logic             dec_start;
  logic [31:0]      dec_data;
  logic [15:0]      dec_len_tcp;
  logic [31:0]      dec_src_ip;
  logic [31:0]      dec_dest_ip;
  logic             dec_fin;
  logic             dec_ok;
  logic             seg_done;
  logic             seg_ok;
  logic             seg_port;
  logic [1:0]       seg_err;
  logic             busy;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    input  req_0, req_1, len_0, len_1, src_ip_0, src_ip_1, dst_ip_0, dst_ip_1,
    input  rd_data_0, rd_data_1, dec_fin, dec_ok,
    output rd_en_0, rd_en_1, dec_reset, dec_start, dec_data, dec_len_tcp,
    output dec_src_ip, dec_dest_ip, seg_done, seg_ok, seg_port, seg_err,
    output busy, acc_cnt, drop_cnt
  );

  modport slave (
    output req_0, req_1, len_0, len_1, src_ip_0, src_ip_1, dst_ip_0, dst_ip_1,
    output rd_data_0, rd_data_1, dec_fin, dec_ok,
    input  rd_en_0, rd_en_1, dec_reset, dec_start, dec_data, dec_len_tcp,
    input  dec_src_ip, dec_dest_ip, seg_done, seg_ok, seg_port, seg_err,
    input  busy, acc_cnt, drop_cnt
  );
endinterface

// File: rtl/tcp_rx_scheduler.sv
// rtl/tcp_rx_scheduler.sv - round-robin sharing of one TCP segment decoder between two ingress queues
module tcp_rx_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  tcp_rx_scheduler_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_CLR    = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  localparam logic [16:0] LP_TIMEOUT = 17'(TIMEOUT);

  logic [2:0]       r_state;
  logic             r_port;
  logic             r_last;
  logic [15:0]      r_len;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [16:0]      r_nwords;
  logic [16:0]      r_cnt;
  logic             r_ok;
  logic [1:0]       r_err;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_drop;

  logic             w_any_req;
  logic             w_grant;
  logic [15:0]      w_len_g;
  logic [16:0]      w_nwords;
  logic [16:0]      w_cnt_inc;
  logic             w_stream;
  logic             w_hold;
  logic             w_report;
  logic             w_pop;

  assign w_any_req = bus.req_0 | bus.req_1;
  // Both requesting: serve the port that was not served last.
  assign w_grant   = (bus.req_0 & bus.req_1) ? ~r_last : bus.req_1;
  assign w_len_g   = w_grant ? bus.len_1 : bus.len_0;
  assign w_nwords  = ({1'b0, w_len_g} + 17'd3) >> 2;
  assign w_cnt_inc = r_cnt + 17'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_port   <= 1'b0;
      r_last   <= 1'b1;
      r_len    <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_nwords <= '0;
      r_cnt    <= '0;
      r_ok     <= 1'b0;
      r_err    <= 2'd0;
      r_acc    <= '0;
      r_drop   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (!w_any_req) begin
            r_state <= S_IDLE;
          end else begin
            r_port   <= w_grant;
            r_len    <= w_len_g;
            r_src    <= w_grant ? bus.src_ip_1 : bus.src_ip_0;
            r_dst    <= w_grant ? bus.dst_ip_1 : bus.dst_ip_0;
            r_nwords <= w_nwords;
            r_cnt    <= '0;
            r_ok     <= 1'b0;
            r_err    <= 2'd0;
            r_state  <= (w_len_g < 16'd20) ? S_DRAIN : S_CLR;
          end
        end
        S_CLR: begin
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_cnt_inc == r_nwords) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          // A finish flag on the final allowed cycle still wins over the watchdog.
          if (bus.dec_fin) begin
            r_ok    <= bus.dec_ok;
            r_err   <= 2'd0;
            r_state <= S_REPORT;
          end else if (w_cnt_inc == LP_TIMEOUT) begin
            r_ok    <= 1'b0;
            r_err   <= 2'd2;
            r_state <= S_REPORT;
          end
        end
        S_DRAIN: begin
          if (w_cnt_inc >= r_nwords) begin
            r_ok    <= 1'b0;
            r_err   <= 2'd1;
            r_state <= S_REPORT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_REPORT: begin
          if (r_ok) begin
            if (!(&r_acc)) r_acc <= r_acc + 1'b1;
          end else begin
            if (!(&r_drop)) r_drop <= r_drop + 1'b1;
          end
          r_last  <= r_port;
          r_state <= w_any_req ? S_ARB : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_stream = (r_state == S_STREAM);
  assign w_hold   = (r_state == S_CLR) | w_stream | (r_state == S_WAIT);
  assign w_report = (r_state == S_REPORT) & ~reset;
  // Drain pops only while words remain, so a zero-length segment pops nothing.
  assign w_pop    = ~reset & (w_stream | ((r_state == S_DRAIN) & (r_cnt < r_nwords)));

  assign bus.rd_en_0     = w_pop & ~r_port;
  assign bus.rd_en_1     = w_pop & r_port;
  assign bus.dec_reset   = reset | ~(w_stream | (r_state == S_WAIT));
  assign bus.dec_start   = ~reset & w_stream & (r_cnt == 17'd0);
  assign bus.dec_data    = w_stream ? (r_port ? bus.rd_data_1 : bus.rd_data_0) : 32'd0;
  assign bus.dec_len_tcp = w_hold ? r_len : 16'd0;
  assign bus.dec_src_ip  = w_hold ? r_src : 32'd0;
  assign bus.dec_dest_ip = w_hold ? r_dst : 32'd0;
  assign bus.seg_done    = w_report;
  assign bus.seg_ok      = w_report & r_ok;
  assign bus.seg_port    = w_report & r_port;
  assign bus.seg_err     = w_report ? r_err : 2'd0;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.acc_cnt     = r_acc;
  assign bus.drop_cnt    = r_drop;
endmodule

// File: tb/tb_tcp_rx_scheduler.sv
// tb/tb_tcp_rx_scheduler.sv - scoreboard bench for tcp_rx_scheduler with queue and decoder models
module tb_tcp_rx_scheduler;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  typedef struct {
    int          len;
    logic [31:0] src;
    logic [31:0] dst;
    bit          ok;
    bit          hang;
    int          delay;
  } seg_t;

  typedef struct {
    bit         ok;
    logic [1:0] err;
  } exp_t;

  logic clk;
  logic reset;

  tcp_rx_scheduler_if #(.CNT_W(CNT_W)) ifc ();

  tcp_rx_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  seg_t        hdr_q [2][$];
  int unsigned wq    [2][$];
  exp_t        exp_q [2][$];
  int          exp_order[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int model_acc  = 0;
  int model_drop = 0;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nw(input int len);
    return (len + 3) / 4;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Enqueue a whole segment and record what the scheduler should report for it.
  task automatic add_seg(input int p, input int len, input bit ok, input bit hang, input int delay);
    seg_t s;
    exp_t e;
    s.len   = len;
    s.src   = $urandom;
    s.dst   = $urandom;
    s.ok    = ok;
    s.hang  = hang;
    s.delay = delay;
    for (int i = 0; i < nw(len); i++) wq[p].push_back($urandom);
    hdr_q[p].push_back(s);
    if (len < 20)  begin e.ok = 1'b0; e.err = 2'd1; end
    else if (hang) begin e.ok = 1'b0; e.err = 2'd2; end
    else           begin e.ok = ok;   e.err = 2'd0; end
    exp_q[p].push_back(e);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (hdr_q[0].size() == 0 && hdr_q[1].size() == 0 && !ifc.busy) begin
        @(negedge clk);
        check("acc_cnt_end", ifc.acc_cnt, sat(model_acc));
        check("drop_cnt_end", ifc.drop_cnt, sat(model_drop));
        return;
      end
    end
    fails++;
    tests++;
    $display("FAIL wait_quiet: scheduler still busy after 20000 cycles, expected idle");
  endtask

  // Monitor, scoreboard, queue and decoder models all live on the falling edge.
  bit   prev_reset = 1'b0;
  bit   prev_dec_reset = 1'b0;
  bit   chk_cnt = 1'b0;
  int   pops[2];
  int   first_pop[2];
  int   last_pop[2];
  int   starts = 0;
  bit   dec_active = 1'b0;
  bit   dec_waiting = 1'b0;
  int   dec_cnt, dec_target, dec_port, countdown, ls_cycle, fin_cycle;
  logic rd[2];

  always @(negedge clk) begin
    rd[0] = ifc.rd_en_0;
    rd[1] = ifc.rd_en_1;
    if (reset) begin
      check("rst_dec_reset", ifc.dec_reset, 1);
      check("rst_rd_en_0", ifc.rd_en_0, 0);
      check("rst_rd_en_1", ifc.rd_en_1, 0);
      check("rst_dec_start", ifc.dec_start, 0);
      if (prev_reset) begin
        check("rst_busy", ifc.busy, 0);
        check("rst_acc_cnt", ifc.acc_cnt, 0);
        check("rst_drop_cnt", ifc.drop_cnt, 0);
      end
      for (int p = 0; p < 2; p++) begin
        hdr_q[p].delete();
        wq[p].delete();
        exp_q[p].delete();
        pops[p] = 0;
      end
      exp_order.delete();
      model_acc   = 0;
      model_drop  = 0;
      starts      = 0;
      dec_active  = 1'b0;
      dec_waiting = 1'b0;
      chk_cnt     = 1'b0;
      ifc.dec_fin = 1'b0;
      ifc.dec_ok  = 1'b0;
    end else begin
      if (chk_cnt) begin
        check("acc_cnt", ifc.acc_cnt, sat(model_acc));
        check("drop_cnt", ifc.drop_cnt, sat(model_drop));
        chk_cnt = 1'b0;
      end
      if (ifc.dec_reset) begin
        ifc.dec_fin = 1'b0;
        ifc.dec_ok  = 1'b0;
        dec_active  = 1'b0;
        dec_waiting = 1'b0;
      end
      if (rd[0] || rd[1]) check("rd_en_overlap", rd[0] & rd[1], 0);
      if (ifc.dec_start) begin
        int sp;
        sp = rd[1] ? 1 : 0;
        if (!(rd[0] || rd[1]) || hdr_q[sp].size() == 0) begin
          check("start_without_pop", rd[0] | rd[1], 1);
        end else begin
          check("start_after_dec_reset", prev_dec_reset, 1);
          check("start_first_word", pops[sp], 0);
          check("dec_len_tcp", ifc.dec_len_tcp, hdr_q[sp][0].len);
          check("dec_src_ip", ifc.dec_src_ip, hdr_q[sp][0].src);
          check("dec_dest_ip", ifc.dec_dest_ip, hdr_q[sp][0].dst);
          starts++;
          dec_active = 1'b1;
          dec_cnt    = 0;
          dec_target = nw(hdr_q[sp][0].len);
          dec_port   = sp;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) begin
          if (wq[p].size() == 0) begin
            check("pop_underflow", p, -1);
          end else begin
            if (!ifc.dec_reset) check("dec_data", ifc.dec_data, wq[p][0]);
            if (pops[p] == 0) first_pop[p] = cyc;
            last_pop[p] = cyc;
            pops[p]++;
            void'(wq[p].pop_front());
          end
        end
      end
      if (dec_active && !ifc.dec_reset && (rd[0] || rd[1])) begin
        dec_cnt++;
        if (dec_cnt == dec_target) begin
          dec_waiting = 1'b1;
          countdown   = hdr_q[dec_port][0].delay;
          ls_cycle    = cyc;
        end
      end else if (dec_waiting && !ifc.dec_reset) begin
        if (!hdr_q[dec_port][0].hang) begin
          if (countdown == 0) begin
            ifc.dec_fin = 1'b1;
            ifc.dec_ok  = hdr_q[dec_port][0].ok;
            fin_cycle   = cyc;
            dec_waiting = 1'b0;
          end else begin
            countdown--;
          end
        end
      end
      if (ifc.seg_done) begin
        int   p;
        exp_t e;
        seg_t h;
        p = ifc.seg_port ? 1 : 0;
        if (exp_q[p].size() == 0 || hdr_q[p].size() == 0) begin
          check("unexpected_seg_done_port", p, -1);
        end else begin
          e = exp_q[p].pop_front();
          h = hdr_q[p][0];
          check("seg_ok", ifc.seg_ok, e.ok);
          check("seg_err", ifc.seg_err, e.err);
          if (exp_order.size() > 0) check("grant_order", p, exp_order.pop_front());
          check("pop_count", pops[p], nw(h.len));
          check("start_count", starts, (h.len >= 20) ? 1 : 0);
          if (nw(h.len) > 0) check("pops_contiguous", last_pop[p] - first_pop[p] + 1, nw(h.len));
          if (e.err == 2'd2)      check("timeout_latency", cyc, ls_cycle + 1 + TIMEOUT);
          else if (e.err == 2'd0) check("fin_latency", cyc, fin_cycle + 1);
          if (e.ok) model_acc++;
          else      model_drop++;
          chk_cnt = 1'b1;
          void'(hdr_q[p].pop_front());
        end
        pops[p] = 0;
        starts  = 0;
      end
    end
    prev_reset     = reset;
    prev_dec_reset = ifc.dec_reset;
    ifc.req_0     = (hdr_q[0].size() != 0);
    ifc.req_1     = (hdr_q[1].size() != 0);
    ifc.len_0     = (hdr_q[0].size() != 0) ? 16'(hdr_q[0][0].len) : 16'd0;
    ifc.len_1     = (hdr_q[1].size() != 0) ? 16'(hdr_q[1][0].len) : 16'd0;
    ifc.src_ip_0  = (hdr_q[0].size() != 0) ? hdr_q[0][0].src : 32'd0;
    ifc.src_ip_1  = (hdr_q[1].size() != 0) ? hdr_q[1][0].src : 32'd0;
    ifc.dst_ip_0  = (hdr_q[0].size() != 0) ? hdr_q[0][0].dst : 32'd0;
    ifc.dst_ip_1  = (hdr_q[1].size() != 0) ? hdr_q[1][0].dst : 32'd0;
    ifc.rd_data_0 = (wq[0].size() != 0) ? wq[0][0] : 32'd0;
    ifc.rd_data_1 = (wq[1].size() != 0) ? wq[1][0] : 32'd0;
  end

  initial begin
    #900000;
    $display("FAIL global_watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Alternation straight after reset: port 0 is preferred first.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      add_seg(0, $urandom_range(20, 60), $urandom_range(0, 1), 1'b0, $urandom_range(0, 7));
      add_seg(1, $urandom_range(20, 60), $urandom_range(0, 1), 1'b0, $urandom_range(0, 7));
      exp_order.push_back(0);
      exp_order.push_back(1);
    end
    wait_quiet();

    @(posedge clk); #1;
    add_seg(0, 24, 1'b1, 1'b0, 2);
    wait_quiet();

    @(posedge clk); #1;
    add_seg(1, 10, 1'b1, 1'b0, 0);
    add_seg(0, 0, 1'b1, 1'b0, 0);
    add_seg(0, 19, 1'b1, 1'b0, 0);
    wait_quiet();

    @(posedge clk); #1;
    add_seg(0, 40, 1'b1, 1'b1, 0);
    add_seg(0, 28, 1'b1, 1'b0, 7);
    add_seg(1, 20, 1'b1, 1'b0, 0);
    wait_quiet();

    @(posedge clk); #1;
    add_seg(1, 1500, 1'b0, 1'b0, 3);
    wait_quiet();

    for (int i = 0; i < 30; i++) begin
      int p, r, len;
      p = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(0, 19);
      else if (r == 1) len = 20;
      else             len = $urandom_range(20, 240);
      add_seg(p, len, $urandom_range(0, 1), ($urandom_range(0, 9) == 0), $urandom_range(0, 7));
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_quiet();

    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) add_seg($urandom_range(0, 1), $urandom_range(0, 19), 1'b1, 1'b0, 0);
    wait_quiet();

    // Reset while a long segment is streaming, then check port 0 wins first again.
    @(posedge clk); #1;
    add_seg(0, 200, 1'b1, 1'b0, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (ifc.rd_en_0 && !ifc.dec_reset) seen = 1'b1;
      end
      check("reached_stream", seen, 1);
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    add_seg(1, 32, 1'b1, 1'b0, 1);
    add_seg(0, 36, 1'b1, 1'b0, 4);
    exp_order.push_back(0);
    exp_order.push_back(1);
    wait_quiet();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
